codificador_serial: RTL and testbench

- Sequential 32-to-5 encoder: the inverse of the 5-to-32 decoder block.
- Accepts a 32-bit multi-hot vector through a valid/ready handshake.
- Emits the 5-bit index of every set bit, one index per output handshake, in priority order. A last-beat flag marks the final index.
- Sits between status/request vectors and index-consuming logic. Its indices can drive the decodificador directly for round-trip checks.

---
 rtl/codificador_serial.sv | 114 +++++++++++
 tb/tb_codificador_serial.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/codificador_serial.sv
// Sequential multi-hot to index encoder: accepts a vector, then emits the index of
// each set bit, one per output handshake, in LSB-first or MSB-first priority order.
module codificador_serial #(
    parameter int WIDTH     = 32,
    parameter int IDX_W     = $clog2(WIDTH),
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic [IDX_W:0]   out_count,
    output logic             zero_flag
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] LSB_ONE = WIDTH'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_pending;
    logic [WIDTH-1:0] w_pending_nxt;
    logic [IDX_W:0]   r_count;
    logic [IDX_W:0]   w_count_nxt;
    logic             r_zero;
    logic             w_zero_nxt;
    logic [IDX_W-1:0] w_idx;
    logic             w_single;
    logic [IDX_W:0]   w_popcnt;

    // Later loop iterations win, so the scan direction sets the priority.
    always_comb begin
        w_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (MSB_FIRST) begin
                if (r_pending[i]) w_idx = IDX_W'(i);
            end else begin
                if (r_pending[WIDTH-1-i]) w_idx = IDX_W'(WIDTH-1-i);
            end
        end
    end

    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_popcnt = w_popcnt + (IDX_W+1)'(in_vec[i]);
        end
    end

    assign w_single = ((r_pending & (r_pending - LSB_ONE)) == '0);

    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        w_count_nxt   = r_count;
        w_zero_nxt    = 1'b0;
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        out_idx       = '0;
        out_last      = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_vec != '0) begin
                        w_pending_nxt = in_vec;
                        w_count_nxt   = w_popcnt;
                        w_state_nxt   = SCAN;
                    end else begin
                        w_count_nxt = '0;
                        w_zero_nxt  = 1'b1;
                    end
                end
            end
            SCAN: begin
                out_valid = 1'b1;
                out_idx   = w_idx;
                out_last  = w_single;
                if (out_ready) begin
                    w_pending_nxt = r_pending & ~(LSB_ONE << w_idx);
                    if (w_single) w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_pending <= '0;
            r_count   <= '0;
            r_zero    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            r_count   <= w_count_nxt;
            r_zero    <= w_zero_nxt;
        end
    end

    assign out_count = r_count;
    assign zero_flag = r_zero;

endmodule

// File: tb/tb_codificador_serial.sv
// Directed and random checks of codificador_serial, LSB-first (dut 0) and
// MSB-first (dut 1) instances, against a bench-side pending-bit model.
module tb_codificador_serial;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  in_valid = '0;
    logic [1:0]  in_ready;
    logic [31:0] in_vec [2];
    logic [1:0]  out_valid;
    logic [1:0]  out_ready = '0;
    logic [4:0]  out_idx [2];
    logic [1:0]  out_last;
    logic [5:0]  out_count [2];
    logic [1:0]  zero_flag;

    int n_chk = 0;
    int n_err = 0;
    int got_q[$];

    always #5 clk = ~clk;

    codificador_serial #(.WIDTH(32), .MSB_FIRST(1'b0)) dut0 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_vec(in_vec[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_idx(out_idx[0]),
        .out_last(out_last[0]), .out_count(out_count[0]), .zero_flag(zero_flag[0])
    );

    codificador_serial #(.WIDTH(32), .MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_vec(in_vec[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_idx(out_idx[1]),
        .out_last(out_last[1]), .out_count(out_count[1]), .zero_flag(zero_flag[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Present one vector and drain it with out_ready=1, checking every beat.
    task automatic run_vec(input int which, input logic [31:0] vec);
        logic [31:0] pend;
        logic [31:0] recon;
        int          exp_i;
        int          waited;
        waited = 0;
        while (!in_ready[which] && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        chk("in_ready_wait", 32'(in_ready[which]), 32'd1);
        in_valid[which]  = 1'b1;
        in_vec[which]    = vec;
        out_ready[which] = 1'b1;
        @(negedge clk);
        in_valid[which] = 1'b0;
        in_vec[which]   = $urandom;
        got_q.delete();
        if (vec == 32'h0) begin
            chk("zero_flag_pulse", 32'(zero_flag[which]), 32'd1);
            chk("zero_no_valid", 32'(out_valid[which]), 32'd0);
            chk("zero_count", 32'(out_count[which]), 32'd0);
            @(negedge clk);
            chk("zero_flag_clear", 32'(zero_flag[which]), 32'd0);
            return;
        end
        chk("count", 32'(out_count[which]), 32'($countones(vec)));
        chk("in_ready_busy", 32'(in_ready[which]), 32'd0);
        pend  = vec;
        recon = 32'h0;
        for (int beat = 0; beat < 34 && pend != 32'h0; beat++) begin
            exp_i = 0;
            for (int b = 0; b < 32; b++) begin
                if (which == 1) begin
                    if (pend[b]) exp_i = b;
                end else begin
                    if (pend[31-b]) exp_i = 31 - b;
                end
            end
            chk("beat_valid", 32'(out_valid[which]), 32'd1);
            chk("beat_idx", 32'(out_idx[which]), 32'(exp_i));
            chk("beat_last", 32'(out_last[which]), 32'($countones(pend) == 1));
            got_q.push_back(int'(out_idx[which]));
            recon = recon | (32'h1 << out_idx[which]);
            pend[exp_i] = 1'b0;
            @(negedge clk);
        end
        chk("drain_done", pend, 32'h0);
        chk("recon", recon, vec);
        chk("idle_valid", 32'(out_valid[which]), 32'd0);
        chk("idle_ready", 32'(in_ready[which]), 32'd1);
        out_ready[which] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        in_vec[0] = '0;
        in_vec[1] = '0;

        // reset held with a vector offered
        in_valid[0] = 1'b1;
        in_vec[0]   = 32'h0000_0001;
        repeat (3) @(negedge clk);
        in_valid[0] = 1'b0;
        chk("rst_in_ready", 32'(in_ready[0]), 32'd1);
        chk("rst_out_valid", 32'(out_valid[0]), 32'd0);
        chk("rst_count", 32'(out_count[0]), 32'd0);
        chk("rst_idx", 32'(out_idx[0]), 32'd0);
        chk("rst_last", 32'(out_last[0]), 32'd0);
        chk("rst_zero", 32'(zero_flag[0]), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_no_beat", 32'(out_valid[0]), 32'd0);

        // sparse
        run_vec(0, 32'h8000_0011);
        chk("sparse_n", 32'(got_q.size()), 32'd3);
        if (got_q.size() == 3) begin
            chk("sparse_i0", 32'(got_q[0]), 32'd0);
            chk("sparse_i1", 32'(got_q[1]), 32'd4);
            chk("sparse_i2", 32'(got_q[2]), 32'd31);
        end

        // back-pressure
        in_valid[0]  = 1'b1;
        in_vec[0]    = 32'h0000_0006;
        out_ready[0] = 1'b0;
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (5) begin
            chk("bp_valid", 32'(out_valid[0]), 32'd1);
            chk("bp_idx", 32'(out_idx[0]), 32'd1);
            chk("bp_last", 32'(out_last[0]), 32'd0);
            @(negedge clk);
        end
        out_ready[0] = 1'b1;
        chk("bp_idx_a", 32'(out_idx[0]), 32'd1);
        chk("bp_last_a", 32'(out_last[0]), 32'd0);
        @(negedge clk);
        chk("bp_idx_b", 32'(out_idx[0]), 32'd2);
        chk("bp_last_b", 32'(out_last[0]), 32'd1);
        @(negedge clk);
        chk("bp_done", 32'(out_valid[0]), 32'd0);
        out_ready[0] = 1'b0;

        // zero and full
        run_vec(0, 32'h0);
        run_vec(0, 32'hFFFF_FFFF);
        chk("full_n", 32'(got_q.size()), 32'd32);
        if (got_q.size() == 32) begin
            chk("full_first", 32'(got_q[0]), 32'd0);
            chk("full_lastidx", 32'(got_q[31]), 32'd31);
        end
        run_vec(0, 32'h0000_0001);
        run_vec(0, 32'h8000_0000);

        // MSB-first
        run_vec(1, 32'h0000_0109);
        chk("msb_n", 32'(got_q.size()), 32'd3);
        if (got_q.size() == 3) begin
            chk("msb_i0", 32'(got_q[0]), 32'd8);
            chk("msb_i1", 32'(got_q[1]), 32'd3);
            chk("msb_i2", 32'(got_q[2]), 32'd0);
        end

        // reset mid-scan
        in_valid[0]  = 1'b1;
        in_vec[0]    = 32'h0000_00F0;
        out_ready[0] = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        chk("ms_idx4", 32'(out_idx[0]), 32'd4);
        @(negedge clk);
        chk("ms_idx5", 32'(out_idx[0]), 32'd5);
        @(negedge clk);
        reset        = 1'b0;
        out_ready[0] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("ms_valid", 32'(out_valid[0]), 32'd0);
        chk("ms_ready", 32'(in_ready[0]), 32'd1);
        chk("ms_count", 32'(out_count[0]), 32'd0);
        out_ready[0] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("ms_no_beat", 32'(out_valid[0]), 32'd0);
        end
        out_ready[0] = 1'b0;

        // random
        for (int i = 0; i < 32; i++) begin
            v = $urandom & $urandom;
            if (i == 5) v = 32'h0;
            run_vec(i % 2, v);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
